// File: rtl/router_cluster_seq_if.sv
// Handshake bundle between the layer controller/PE array (master) and the
// west-side router-cluster phase sequencer (slave).
interface router_cluster_seq_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_num_wght;
    logic [CNT_W-1:0] cfg_num_iact;
    logic [CNT_W-1:0] cfg_num_psum;
    logic             wght_beat;
    logic             iact_beat;
    logic             psum_beat;
    logic             compute_done;
    logic [3:0]       router_mode_wght;
    logic [3:0]       router_mode_iact;
    logic [3:0]       router_mode_psum;
    logic             busy;
    logic             done;
    logic [2:0]       phase;

    // Beats are plain strobes: one transfer per cycle the strobe is high while
    // the owning phase is active; there is no back-pressure towards the routers.
    modport master (
        output start, abort, cfg_num_wght, cfg_num_iact, cfg_num_psum,
        output wght_beat, iact_beat, psum_beat, compute_done,
        input  router_mode_wght, router_mode_iact, router_mode_psum,
        input  busy, done, phase
    );

    modport slave (
        input  start, abort, cfg_num_wght, cfg_num_iact, cfg_num_psum,
        input  wght_beat, iact_beat, psum_beat, compute_done,
        output router_mode_wght, router_mode_iact, router_mode_psum,
        output busy, done, phase
    );
endinterface

// File: rtl/router_cluster_seq.sv
// Phase sequencer for one west router cluster: weight load, iact load,
// compute, psum drain, driving registered router_mode codes for each phase.
module router_cluster_seq #(
    parameter int         CNT_W          = 10,
    parameter logic [3:0] MODE_IDLE      = 4'd0,
    parameter logic [3:0] MODE_WGHT_LOAD = 4'd1,
    parameter logic [3:0] MODE_IACT_LOAD = 4'd1,
    parameter logic [3:0] MODE_PSUM_ACC  = 4'd2,
    parameter logic [3:0] MODE_PSUM_OUT  = 4'd3
) (
    input logic                  clk,
    input logic                  reset,
    router_cluster_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_W   = 3'd1,
        S_LOAD_A   = 3'd2,
        S_COMPUTE  = 3'd3,
        S_PSUM_OUT = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_num_w, r_num_a, r_num_p;
    logic [CNT_W-1:0] r_wcnt, r_acnt, r_pcnt;
    logic [3:0]       r_mode_w, r_mode_a, r_mode_p;
    logic [3:0]       w_mode_w, w_mode_a, w_mode_p;
    logic             r_busy, r_done;
    logic             w_accept;
    logic             w_w_last, w_a_last, w_p_last;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;
    // Terminal beat is detected by compare so a full-scale count never wraps.
    assign w_w_last = bus.wght_beat && (r_wcnt == r_num_w - CNT_W'(1));
    assign w_a_last = bus.iact_beat && (r_acnt == r_num_a - CNT_W'(1));
    assign w_p_last = bus.psum_beat && (r_pcnt == r_num_p - CNT_W'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.cfg_num_wght != '0)      w_next = S_LOAD_W;
                    else if (bus.cfg_num_iact != '0) w_next = S_LOAD_A;
                    else                             w_next = S_COMPUTE;
                end
            end
            S_LOAD_W: begin
                if (w_w_last) w_next = (r_num_a != '0) ? S_LOAD_A : S_COMPUTE;
            end
            S_LOAD_A: begin
                if (w_a_last) w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (bus.compute_done) w_next = (r_num_p != '0) ? S_PSUM_OUT : S_DONE;
            end
            S_PSUM_OUT: begin
                if (w_p_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end

    // Modes are decoded from the target state so they are valid with it.
    always_comb begin
        w_mode_w = MODE_IDLE;
        w_mode_a = MODE_IDLE;
        w_mode_p = MODE_IDLE;
        case (w_next)
            S_LOAD_W:   w_mode_w = MODE_WGHT_LOAD;
            S_LOAD_A:   w_mode_a = MODE_IACT_LOAD;
            S_COMPUTE:  w_mode_p = MODE_PSUM_ACC;
            S_PSUM_OUT: w_mode_p = MODE_PSUM_OUT;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mode_w <= MODE_IDLE;
            r_mode_a <= MODE_IDLE;
            r_mode_p <= MODE_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mode_w <= w_mode_w;
            r_mode_a <= w_mode_a;
            r_mode_p <= w_mode_p;
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_w <= '0;
            r_num_a <= '0;
            r_num_p <= '0;
            r_wcnt  <= '0;
            r_acnt  <= '0;
            r_pcnt  <= '0;
        end else if (bus.abort) begin
            r_wcnt  <= '0;
            r_acnt  <= '0;
            r_pcnt  <= '0;
        end else if (w_accept) begin
            r_num_w <= bus.cfg_num_wght;
            r_num_a <= bus.cfg_num_iact;
            r_num_p <= bus.cfg_num_psum;
            r_wcnt  <= '0;
            r_acnt  <= '0;
            r_pcnt  <= '0;
        end else begin
            if (r_state == S_LOAD_W   && bus.wght_beat) r_wcnt <= r_wcnt + CNT_W'(1);
            if (r_state == S_LOAD_A   && bus.iact_beat) r_acnt <= r_acnt + CNT_W'(1);
            if (r_state == S_PSUM_OUT && bus.psum_beat) r_pcnt <= r_pcnt + CNT_W'(1);
        end
    end

    assign bus.router_mode_wght = r_mode_w;
    assign bus.router_mode_iact = r_mode_a;
    assign bus.router_mode_psum = r_mode_p;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.phase            = r_state;
endmodule

// File: tb/tb_router_cluster_seq.sv
// Bench for router_cluster_seq: directed scenarios plus a random run, all
// checked cycle by cycle against a remaining-beats reference model.
module tb_router_cluster_seq;
  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  router_cluster_seq_if #(.CNT_W(10)) bus ();

  router_cluster_seq #(.CNT_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase number plus the beats still owed by each data path.
  int m_ph;
  int m_rw, m_ra, m_rp;

  task automatic model_reset();
    m_ph = 0; m_rw = 0; m_ra = 0; m_rp = 0;
  endtask

  task automatic model_step();
    if (bus.abort) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: if (bus.start) begin
             m_rw = int'(bus.cfg_num_wght);
             m_ra = int'(bus.cfg_num_iact);
             m_rp = int'(bus.cfg_num_psum);
             m_ph = (m_rw > 0) ? 1 : (m_ra > 0) ? 2 : 3;
           end
        1: if (bus.wght_beat) begin
             m_rw = m_rw - 1;
             if (m_rw == 0) m_ph = (m_ra > 0) ? 2 : 3;
           end
        2: if (bus.iact_beat) begin
             m_ra = m_ra - 1;
             if (m_ra == 0) m_ph = 3;
           end
        3: if (bus.compute_done) m_ph = (m_rp > 0) ? 4 : 5;
        4: if (bus.psum_beat) begin
             m_rp = m_rp - 1;
             if (m_rp == 0) m_ph = 5;
           end
        default: m_ph = 0;
      endcase
    end
  endtask

  function automatic logic [16:0] exp_vec();
    logic [3:0] mw, ma, mp;
    mw = (m_ph == 1) ? 4'd1 : 4'd0;
    ma = (m_ph == 2) ? 4'd1 : 4'd0;
    mp = (m_ph == 3) ? 4'd2 : (m_ph == 4) ? 4'd3 : 4'd0;
    return {3'(m_ph), mw, ma, mp, (m_ph != 0), (m_ph == 5)};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.phase, bus.router_mode_wght, bus.router_mode_iact,
            bus.router_mode_psum, bus.busy, bus.done};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.start = 0; bus.abort = 0; bus.compute_done = 0;
    bus.wght_beat = 0; bus.iact_beat = 0; bus.psum_beat = 0;
  endtask

  task automatic set_cfg(input int w, input int a, input int p);
    bus.cfg_num_wght = 10'(w);
    bus.cfg_num_iact = 10'(a);
    bus.cfg_num_psum = 10'(p);
  endtask

  task automatic set_beats(input logic w, input logic a, input logic p);
    bus.wght_beat = w; bus.iact_beat = a; bus.psum_beat = p;
  endtask

  // One clock: the model consumes the same inputs the DUT sees at the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    set_cfg(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (obs_vec() !== 17'h0) begin
      n_bad++;
      $display("FAIL reset got=%h exp=%h", obs_vec(), 17'h0);
    end
    reset = 1'b0;
    step();
    n_total++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_idle got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_nominal();
    int dones = 0;
    clear_inputs();
    set_cfg(3, 5, 2);
    bus.start = 1;
    step();
    bus.start = 0;
    n_total++;
    if (bus.phase !== 3'd1 || bus.router_mode_wght !== 4'd1) begin
      n_bad++;
      $display("FAIL nominal_first got=%0d/%0d exp=1/1", bus.phase, bus.router_mode_wght);
    end
    for (int i = 0; i < 20; i++) begin
      set_beats(1, 1, 1);
      bus.compute_done = (i == 10);
      step();
      if (bus.done === 1'b1) dones++;
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL nominal cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    n_total++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL nominal_done_pulses got=%0d exp=1", dones);
    end
  endtask

  task automatic test_skipped();
    clear_inputs();
    set_cfg(0, 0, 0);
    bus.start = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.start = 0;
      bus.compute_done = (i == 3);
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL skipped cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_gapped_stray();
    logic [4:0] pat;
    int w_cycles = 0;
    pat = 5'b11001;
    clear_inputs();
    set_cfg(3, 2, 1);
    bus.start = 1;
    step();
    bus.start = 0;
    if (bus.phase === 3'd1) w_cycles++;
    for (int i = 0; i < 5; i++) begin
      set_beats(pat[i], 1, 1);
      step();
      if (bus.phase === 3'd1) w_cycles++;
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL gapped cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    n_total++;
    if (w_cycles != 5) begin
      n_bad++;
      $display("FAIL gapped_loadw_len got=%0d exp=5", w_cycles);
    end
    for (int i = 0; i < 6; i++) begin
      set_beats(0, (i < 2), (i == 3));
      bus.compute_done = (i == 2);
      step();
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL gapped_tail cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_abort();
    clear_inputs();
    set_cfg(0, 5, 0);
    bus.start = 1;
    step();
    bus.start = 0;
    for (int i = 0; i < 3; i++) begin
      set_beats(0, 1, 0);
      bus.abort = (i == 2);
      step();
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    n_total++;
    if (bus.phase !== 3'd0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle got=%0d/%b exp=0/0", bus.phase, bus.done);
    end
    bus.start = 1;
    step();
    bus.start = 0;
    for (int i = 0; i < 9; i++) begin
      set_beats(0, (i < 5), 0);
      bus.compute_done = (i == 6);
      step();
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL abort_rerun cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_start_busy();
    clear_inputs();
    set_cfg(1, 0, 1);
    bus.start = 1;
    step();
    bus.start = 0;
    set_beats(1, 0, 0);
    step();
    set_beats(0, 0, 0);
    // COMPUTE now: stray start and new cfg must not disturb the run.
    set_cfg(2, 2, 0);
    for (int i = 0; i < 6; i++) begin
      bus.start = (i == 0);
      bus.compute_done = (i == 2);
      bus.psum_beat = (i == 3);
      step();
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL start_busy cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    set_cfg(0, 0, 2);
    bus.start = 1;
    step();
    bus.start = 0;
    bus.abort = 1;
    bus.compute_done = 1;
    step();
    clear_inputs();
    n_total++;
    if (obs_vec() !== exp_vec() || bus.phase !== 3'd0) begin
      n_bad++;
      $display("FAIL abort_vs_done got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_max_count();
    int bad_here = 0;
    clear_inputs();
    set_cfg(1023, 0, 0);
    bus.start = 1;
    step();
    bus.start = 0;
    for (int i = 0; i < 1026; i++) begin
      set_beats(1, 0, 0);
      bus.compute_done = (i == 1023);
      step();
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        bad_here++;
        if (bad_here < 5)
          $display("FAIL max_count cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int bad_here = 0;
    clear_inputs();
    for (int i = 0; i < 600; i++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      bus.start        = ($urandom_range(0, 3) == 0);
      bus.abort        = ($urandom_range(0, 39) == 0);
      bus.compute_done = ($urandom_range(0, 3) == 0);
      set_beats($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      step();
      n_total++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        bad_here++;
        if (bad_here < 8)
          $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    clear_inputs();
    set_cfg(0, 0, 3);
    bus.start = 1;
    step();
    bus.start = 0;
    bus.compute_done = 1;
    step();
    bus.compute_done = 0;
    bus.psum_beat = 1;
    step();
    bus.psum_beat = 0;
    n_total++;
    if (obs_vec() !== exp_vec() || bus.phase !== 3'd4) begin
      n_bad++;
      $display("FAIL reset_mid_pre got=%h exp=%h", obs_vec(), exp_vec());
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (obs_vec() !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 17'h0);
    end
    reset = 1'b0;
    while (guard < 4) begin
      step();
      guard++;
    end
    n_total++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_mid_after got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_skipped();
    test_gapped_stray();
    test_abort();
    test_start_busy();
    test_max_count();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/router_cluster_seq.md
Name: router_cluster_seq

Overview:
- Phase sequencer for one west-side router cluster (iact, wght and psum routers).
- On a start command it drives the three router_mode buses through four phases in order: weight load, iact load, compute, psum drain.
- It counts the transfer strobes on each data path to decide when each phase is complete.
- It sits between the top-level layer controller and the router cluster; it replaces static tie-offs of the router_mode inputs.

Parameters:
- CNT_W, 10, width of the beat counters and of the cfg_num_* inputs.
- MODE_IDLE, 4'd0, router_mode code meaning "no transfer"; applies to all three routers.
- MODE_WGHT_LOAD, 4'd1, wght router code for GLB-to-PE weight delivery.
- MODE_IACT_LOAD, 4'd1, iact router code for GLB-to-PE activation delivery.
- MODE_PSUM_ACC, 4'd2, psum router code for vertical accumulation during compute.
- MODE_PSUM_OUT, 4'd3, psum router code for writing psums back to the GLB.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle command; accepted only in IDLE
- abort  in  1  synchronous abort, honoured in any state
- cfg_num_wght  in  CNT_W  weight beats to transfer; 0 skips the phase
- cfg_num_iact  in  CNT_W  iact beats to transfer; 0 skips the phase
- cfg_num_psum  in  CNT_W  psum beats to drain; 0 skips the phase
- wght_beat  in  1  connected to the wght router west enable input; one beat per high cycle
- iact_beat  in  1  connected to the iact router west enable input
- psum_beat  in  1  connected to the psum router west enable output
- compute_done  in  1  PE array reports that accumulation is finished (pulse)
- router_mode_wght  out  4  registered mode for the wght router
- router_mode_iact  out  4  registered mode for the iact router
- router_mode_psum  out  4  registered mode for the psum router
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes
- phase  out  3  current state encoding: IDLE=0, LOAD_W=1, LOAD_A=2, COMPUTE=3, PSUM_OUT=4, DONE=5

Behaviour:
- Reset values: state IDLE; all router_mode outputs = MODE_IDLE; busy=0; done=0; phase=0; counters=0.
- All outputs are registered. No combinational path runs from any input to any output.
- IDLE:
  - When start=1 and abort=0, latch cfg_num_* into internal registers and clear all counters.
  - Next state is the first phase whose latched count is non-zero, in the order LOAD_W, LOAD_A; otherwise COMPUTE.
  - Mode outputs take the target state's value on the same clock edge, so they are valid 1 cycle after start.
- LOAD_W:
  - router_mode_wght = MODE_WGHT_LOAD; the other two modes = MODE_IDLE.
  - Each wght_beat increments wcnt.
  - A beat arriving while wcnt == num_wght-1 completes the phase. Next cycle: LOAD_A if num_iact != 0, else COMPUTE.
  - iact_beat and psum_beat are ignored in this state.
- LOAD_A:
  - router_mode_iact = MODE_IACT_LOAD; the other two modes = MODE_IDLE.
  - Counts iact_beat the same way as LOAD_W; the next state is COMPUTE.
- COMPUTE:
  - router_mode_psum = MODE_PSUM_ACC; iact and wght modes = MODE_IDLE.
  - Holds until compute_done=1. Next: PSUM_OUT if num_psum != 0, else DONE.
- PSUM_OUT:
  - router_mode_psum = MODE_PSUM_OUT.
  - Counts psum_beat up to num_psum, then goes to DONE.
- DONE:
  - All modes = MODE_IDLE; done=1 for exactly this one cycle; next state is IDLE.
  - busy is 1 in DONE and 0 from the following cycle.
- Beats outside the owning phase are ignored and do not alter any counter.
- compute_done outside COMPUTE is ignored.
- start while busy is ignored. Changes to cfg_num_* after start is accepted have no effect until the next start.
- abort:
  - abort=1 in any state forces IDLE on the next edge, with all modes = MODE_IDLE, counters cleared and no done pulse.
  - abort has priority over start and over every phase transition in the same cycle.
- Counters never wrap. A count of 2^CNT_W-1 is legal and is terminated by the compare, not by overflow.
- Asynchronous reset mid-run immediately returns every output to its reset value.

Test Plan:
- Nominal run:
  - Stimulus: cfg w=3, a=5, p=2; start at cycle 0; beats on every cycle.
  - Response: phase sequence 1,1,1 / 2 ×5 / 3 until compute_done / 4,4 / 5 / 0. Modes match each phase and are valid at cycle 1. done is high for exactly 1 cycle.
- Skipped phases:
  - Stimulus: cfg w=0, a=0, p=0; start, then compute_done 4 cycles later.
  - Response: phase 0→3→5→0; router_mode_wght and router_mode_iact stay 0 throughout.
- Gapped and stray beats:
  - Stimulus: wght_beat pattern 1,0,0,1,1 with w=3; iact_beat and psum_beat pulsed during LOAD_W.
  - Response: LOAD_W lasts 5 cycles; the iact count is unaffected (LOAD_A still needs a full a beats).
- Abort:
  - Stimulus: assert abort in LOAD_A after 2 of 5 beats, then start a new run with a=5.
  - Response: IDLE next cycle with no done pulse; the new run requires all 5 iact beats.
- Start while busy, and simultaneous events:
  - Stimulus: pulse start during COMPUTE; in a separate run, assert abort together with compute_done.
  - Response: the extra start is ignored. With abort and compute_done together, the next state is IDLE, not PSUM_OUT.
- Reset mid-run:
  - Stimulus: assert reset asynchronously during PSUM_OUT.
  - Response: modes=0, busy=0, phase=0 immediately, without waiting for a clock edge.
